// File: rtl/conv_window_sequencer_if.sv
// rtl/conv_window_sequencer_if.sv - line buffer, MAC and result handshake signals of the window sequencer
interface conv_window_sequencer_if #(
  parameter int point_width = 8
);
  logic                     lb_en_read;
  logic                     lb_slide;
  logic                     lb_window_rdy;
  logic                     mac_start;
  logic                     mac_done;
  logic [2*point_width-1:0] mac_result;
  logic                     out_valid;
  logic                     out_ready;
  logic [2*point_width-1:0] out_data;
  logic [5:0]               out_row;
  logic [5:0]               out_col;

  modport master (
    output lb_en_read, lb_slide, mac_start, out_valid, out_data, out_row, out_col,
    input  lb_window_rdy, mac_done, mac_result, out_ready
  );

  modport slave (
    input  lb_en_read, lb_slide, mac_start, out_valid, out_data, out_row, out_col,
    output lb_window_rdy, mac_done, mac_result, out_ready
  );
endinterface

// File: rtl/conv_window_sequencer.sv
// rtl/conv_window_sequencer.sv - control FSM stepping the line buffer and MAC through one convolution pass
module conv_window_sequencer #(
  parameter int kernel_size    = 2,
  parameter int data_width     = 4,
  parameter int data_height    = 4,
  parameter int point_width    = 8,
  parameter int timeout_cycles = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [11:0]            win_count,
  conv_window_sequencer_if.master bus
);
  localparam int               out_cols    = data_width - kernel_size + 1;
  localparam int               out_rows    = data_height - kernel_size + 1;
  localparam logic [11:0]      last_window = 12'(out_cols * out_rows - 1);
  localparam logic [5:0]       last_col    = 6'(out_cols - 1);
  localparam logic [7:0]       timer_last  = 8'(timeout_cycles - 1);

  // One-hot encoding so every strobe is a state flop output.
  typedef enum logic [7:0] {
    st_idle     = 8'h01,
    st_load     = 8'h02,
    st_wait_win = 8'h04,
    st_mac_go   = 8'h08,
    st_wait_mac = 8'h10,
    st_result   = 8'h20,
    st_slide    = 8'h40,
    st_finish   = 8'h80
  } state_t;

  state_t                   state;
  logic [7:0]               state_bits;
  logic [7:0]               timer;
  logic                     timer_expired;
  logic [2*point_width-1:0] result_q;
  logic [5:0]               row_q;
  logic [5:0]               col_q;

  assign state_bits    = state;
  assign timer_expired = (timer == timer_last);

  assign busy           = ~state_bits[0];
  assign bus.lb_en_read = state_bits[1];
  assign bus.mac_start  = state_bits[3];
  assign bus.out_valid  = state_bits[5];
  assign bus.lb_slide   = state_bits[6];
  assign done           = state_bits[7];
  assign bus.out_data   = result_q;
  assign bus.out_row    = row_q;
  assign bus.out_col    = col_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= st_idle;
      timer     <= 8'd0;
      error     <= 1'b0;
      win_count <= 12'd0;
      result_q  <= '0;
      row_q     <= 6'd0;
      col_q     <= 6'd0;
    end else begin
      // Timer only survives while a wait state holds; any transition clears it.
      timer <= 8'd0;
      unique case (state)
        st_idle: begin
          if (start) begin
            state     <= st_load;
            error     <= 1'b0;
            win_count <= 12'd0;
            row_q     <= 6'd0;
            col_q     <= 6'd0;
          end
        end
        st_load: state <= st_wait_win;
        st_wait_win: begin
          if (bus.lb_window_rdy) begin
            state <= st_mac_go;
          end else if (timer_expired) begin
            state <= st_idle;
            error <= 1'b1;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        st_mac_go: state <= st_wait_mac;
        st_wait_mac: begin
          if (bus.mac_done) begin
            state    <= st_result;
            result_q <= bus.mac_result;
          end else if (timer_expired) begin
            state <= st_idle;
            error <= 1'b1;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        st_result: begin
          if (bus.out_ready) begin
            win_count <= win_count + 12'd1;
            if (win_count == last_window) begin
              state <= st_finish;
            end else begin
              state <= st_slide;
              if (col_q == last_col) begin
                col_q <= 6'd0;
                row_q <= row_q + 6'd1;
              end else begin
                col_q <= col_q + 6'd1;
              end
            end
          end else if (timer_expired) begin
            state <= st_idle;
            error <= 1'b1;
          end else begin
            timer <= timer + 8'd1;
          end
        end
        st_slide:  state <= st_wait_win;
        st_finish: state <= st_idle;
        default:   state <= st_idle;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_window_sequencer.sv
// tb/tb_conv_window_sequencer.sv - table-driven and randomized bench for conv_window_sequencer
`timescale 1ns/1ps
module tb_conv_window_sequencer;
  localparam int d0_w = 4, d0_h = 4, d0_k = 2;
  localparam int d1_w = 5, d1_h = 3, d1_k = 3;

  typedef struct {
    int d; int lb_lat; int mac_lat; int rdy_mode; int never; int stray; int hold_at; int hold_len;
    int exp_hs; int exp_slides; int exp_macs; int exp_done; int exp_err; int exp_row; int exp_col; int exp_busy;
  } vec_t;

  logic clock;
  logic reset [2];
  logic start [2];
  logic busy_w [2];
  logic done_w [2];
  logic error_w [2];
  logic [11:0] wc_w [2];
  logic lb_rdy [2];
  logic mac_done [2];
  logic [15:0] mac_result [2];
  logic out_ready [2];
  logic en_w [2];
  logic sl_w [2];
  logic ms_w [2];
  logic ov_w [2];
  logic [15:0] od_w [2];
  logic [5:0] row_w [2];
  logic [5:0] col_w [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int out_cols [2];
  int out_rows [2];
  int lb_lat [2], mac_lat [2], lb_wait [2], mac_wait [2];
  int mac_never [2], stray [2], noise [2], rdy_mode [2], stall [2];
  int hold_at [2], hold_len [2], hold_cnt [2];
  int n_en [2], n_sl [2], n_ms [2], n_dn [2], n_hs [2], last_hs_cyc [2];
  logic [15:0] last_mac [2];
  logic prev_stall [2];
  logic [27:0] prev_res [2];

  conv_window_sequencer_if #(.point_width(8)) bus0 ();
  conv_window_sequencer_if #(.point_width(8)) bus1 ();

  conv_window_sequencer #(
    .kernel_size(d0_k), .data_width(d0_w), .data_height(d0_h), .point_width(8), .timeout_cycles(255)
  ) dut0 (
    .clock(clock), .reset(reset[0]), .start(start[0]), .busy(busy_w[0]), .done(done_w[0]),
    .error(error_w[0]), .win_count(wc_w[0]), .bus(bus0)
  );

  conv_window_sequencer #(
    .kernel_size(d1_k), .data_width(d1_w), .data_height(d1_h), .point_width(8), .timeout_cycles(8)
  ) dut1 (
    .clock(clock), .reset(reset[1]), .start(start[1]), .busy(busy_w[1]), .done(done_w[1]),
    .error(error_w[1]), .win_count(wc_w[1]), .bus(bus1)
  );

  assign bus0.lb_window_rdy = lb_rdy[0];
  assign bus0.mac_done      = mac_done[0];
  assign bus0.mac_result    = mac_result[0];
  assign bus0.out_ready     = out_ready[0];
  assign bus1.lb_window_rdy = lb_rdy[1];
  assign bus1.mac_done      = mac_done[1];
  assign bus1.mac_result    = mac_result[1];
  assign bus1.out_ready     = out_ready[1];
  assign en_w[0] = bus0.lb_en_read;  assign en_w[1] = bus1.lb_en_read;
  assign sl_w[0] = bus0.lb_slide;    assign sl_w[1] = bus1.lb_slide;
  assign ms_w[0] = bus0.mac_start;   assign ms_w[1] = bus1.mac_start;
  assign ov_w[0] = bus0.out_valid;   assign ov_w[1] = bus1.out_valid;
  assign od_w[0] = bus0.out_data;    assign od_w[1] = bus1.out_data;
  assign row_w[0] = bus0.out_row;    assign row_w[1] = bus1.out_row;
  assign col_w[0] = bus0.out_col;    assign col_w[1] = bus1.out_col;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input int d, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d: got %0d, expected %0d", name, d, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_counts(input int d);
    n_en[d] = 0; n_sl[d] = 0; n_ms[d] = 0; n_dn[d] = 0; n_hs[d] = 0;
    last_hs_cyc[d] = -10; stall[d] = 0; prev_stall[d] = 1'b0;
  endtask

  task automatic check_idle_zero(input int d, input string tag);
    check({tag, "_busy"}, d, busy_w[d], 0);
    check({tag, "_done"}, d, done_w[d], 0);
    check({tag, "_error"}, d, error_w[d], 0);
    check({tag, "_en_read"}, d, en_w[d], 0);
    check({tag, "_slide"}, d, sl_w[d], 0);
    check({tag, "_mac_start"}, d, ms_w[d], 0);
    check({tag, "_out_valid"}, d, ov_w[d], 0);
    check({tag, "_out_data"}, d, od_w[d], 0);
    check({tag, "_out_row"}, d, row_w[d], 0);
    check({tag, "_out_col"}, d, col_w[d], 0);
    check({tag, "_win_count"}, d, wc_w[d], 0);
  endtask

  // Environment: line-buffer and MAC stubs, downstream sink, and the result scoreboard.
  initial begin
    for (int d = 0; d < 2; d++) begin
      lb_rdy[d] = 1'b0; mac_done[d] = 1'b0; mac_result[d] = 16'd0; out_ready[d] = 1'b0;
      lb_lat[d] = 1; mac_lat[d] = 1; lb_wait[d] = 0; mac_wait[d] = 0;
      mac_never[d] = 0; stray[d] = 0; noise[d] = 0; rdy_mode[d] = 0;
      hold_at[d] = -1; hold_len[d] = 0; hold_cnt[d] = 0;
      last_mac[d] = 16'd0; prev_res[d] = 28'd0;
      clear_counts(d);
    end
    forever begin
      @(negedge clock);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (en_w[d]) n_en[d]++;
        if (ms_w[d]) n_ms[d]++;
        if (sl_w[d]) begin
          n_sl[d]++;
          check("slide_follows_accept", d, n_sl[d], n_hs[d]);
        end
        if (done_w[d]) begin
          n_dn[d]++;
          check("done_after_last_accept", d, cyc, last_hs_cyc[d] + 1);
        end
        if (ov_w[d] && prev_stall[d])
          check("held_result", d, {row_w[d], col_w[d], od_w[d]}, prev_res[d]);

        if (ov_w[d] && hold_at[d] == n_hs[d] && hold_cnt[d] < hold_len[d]) begin
          out_ready[d] = 1'b0;
          hold_cnt[d]++;
        end else if (rdy_mode[d] == 0 || stall[d] >= 3) begin
          out_ready[d] = 1'b1;
        end else begin
          out_ready[d] = 1'($urandom_range(0, 1));
        end
        stall[d] = (ov_w[d] && !out_ready[d]) ? stall[d] + 1 : 0;

        if (ov_w[d] && out_ready[d]) begin
          check("result_data", d, od_w[d], last_mac[d]);
          check("result_row", d, row_w[d], n_hs[d] / out_cols[d]);
          check("result_col", d, col_w[d], n_hs[d] % out_cols[d]);
          check("result_win_count", d, wc_w[d], n_hs[d]);
          n_hs[d]++;
          last_hs_cyc[d] = cyc;
        end
        prev_stall[d] = ov_w[d] && !out_ready[d];
        prev_res[d] = {row_w[d], col_w[d], od_w[d]};

        mac_done[d] = 1'b0;
        if (mac_wait[d] > 0) begin
          mac_wait[d]--;
          if (mac_wait[d] == 0) begin
            mac_result[d] = 16'($urandom);
            last_mac[d] = mac_result[d];
            mac_done[d] = 1'b1;
          end
        end
        if (ms_w[d]) begin
          if (mac_never[d] == 0) mac_wait[d] = mac_lat[d];
          if (stray[d] != 0) begin
            mac_done[d] = 1'b1;
            mac_result[d] = ~last_mac[d];
          end
        end

        if (lb_wait[d] > 0) begin
          lb_wait[d]--;
          if (lb_wait[d] == 0) lb_rdy[d] = 1'b1;
        end
        if (en_w[d] || sl_w[d]) begin
          lb_rdy[d] = 1'b0;
          lb_wait[d] = lb_lat[d];
        end
        if (noise[d] != 0) begin
          lb_rdy[d] = 1'($urandom_range(0, 1));
          mac_done[d] = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int d;
    int n;
    d = v.d;
    clear_counts(d);
    lb_lat[d] = v.lb_lat; mac_lat[d] = v.mac_lat; rdy_mode[d] = v.rdy_mode;
    mac_never[d] = v.never; stray[d] = v.stray;
    hold_at[d] = v.hold_at; hold_len[d] = v.hold_len; hold_cnt[d] = 0;
    start[d] = 1'b1;
    tick();
    start[d] = 1'b0;
    check("load_strobe", d, en_w[d], 1);
    check("busy_in_load", d, busy_w[d], 1);
    check("error_cleared_by_start", d, error_w[d], 0);
    n = 1;
    while (busy_w[d] && n < 4000) begin
      if (v.stray != 0) start[d] = 1'($urandom_range(0, 1));
      tick();
      if (busy_w[d]) n++;
    end
    start[d] = 1'b0;
    check("pass_terminates", d, busy_w[d], 0);
    tick();
    check("windows_accepted", d, n_hs[d], v.exp_hs);
    check("slide_strobes", d, n_sl[d], v.exp_slides);
    check("mac_starts", d, n_ms[d], v.exp_macs);
    check("load_strobes", d, n_en[d], 1);
    check("done_pulses", d, n_dn[d], v.exp_done);
    check("error_flag", d, error_w[d], v.exp_err);
    check("final_win_count", d, wc_w[d], v.exp_hs);
    check("final_row", d, row_w[d], v.exp_row);
    check("final_col", d, col_w[d], v.exp_col);
    if (v.exp_busy != 0) check("busy_cycles", d, n, v.exp_busy);
    if (v.hold_at >= 0) check("held_cycles", d, hold_cnt[d], v.hold_len);
  endtask

  vec_t vecs [6];
  vec_t rv;
  int   rd;
  int   wait_n;

  initial begin
    out_cols[0] = d0_w - d0_k + 1; out_rows[0] = d0_h - d0_k + 1;
    out_cols[1] = d1_w - d1_k + 1; out_rows[1] = d1_h - d1_k + 1;
    //           d lb mac rdy nev str hold len  hs sl ms dn er row col busy
    vecs[0] = '{0, 1, 1,  0,  0,  0,  -1, 0,   9, 8, 9, 1, 0, 2,  2,  46};
    vecs[1] = '{0, 1, 1,  0,  0,  0,   3, 10,  9, 8, 9, 1, 0, 2,  2,  56};
    vecs[2] = '{1, 1, 1,  0,  0,  0,  -1, 0,   3, 2, 3, 1, 0, 0,  2,  16};
    vecs[3] = '{1, 1, 1,  0,  1,  0,  -1, 0,   0, 0, 1, 0, 1, 0,  0,  11};
    vecs[4] = '{1, 2, 3,  1,  0,  1,  -1, 0,   3, 2, 3, 1, 0, 0,  2,  0};
    vecs[5] = '{0, 3, 2,  1,  0,  1,  -1, 0,   9, 8, 9, 1, 0, 2,  2,  0};

    for (int d = 0; d < 2; d++) begin
      reset[d] = 1'b1;
      start[d] = 1'b0;
    end
    tick();
    tick();
    check_idle_zero(0, "reset");
    check_idle_zero(1, "reset");
    reset[0] = 1'b0;
    reset[1] = 1'b0;
    tick();

    clear_counts(0);
    noise[0] = 1;
    repeat (6) tick();
    noise[0] = 0;
    tick();
    check("idle_noise_busy", 0, busy_w[0], 0);
    check("idle_noise_strobes", 0, n_en[0] + n_sl[0] + n_ms[0] + n_dn[0], 0);
    check("idle_noise_valid", 0, ov_w[0], 0);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    clear_counts(0);
    lb_lat[0] = 1; mac_lat[0] = 4; rdy_mode[0] = 0; mac_never[0] = 0; stray[0] = 0;
    hold_at[0] = -1; hold_len[0] = 0;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wait_n = 0;
    while (n_ms[0] < 5 && wait_n < 500) begin
      tick();
      wait_n++;
    end
    check("reached_window5", 0, n_ms[0], 5);
    tick();
    reset[0] = 1'b1;
    tick();
    check_idle_zero(0, "mid_pass_reset");
    reset[0] = 1'b0;
    mac_wait[0] = 0;
    mac_done[0] = 1'b0;
    tick();
    check("post_reset_strobes", 0, {en_w[0], sl_w[0], ms_w[0], done_w[0], busy_w[0]}, 0);
    run_vec(vecs[0]);

    for (int r = 0; r < 16; r++) begin
      rd = $urandom_range(0, 1);
      rv.d = rd;
      rv.lb_lat = $urandom_range(1, 4);
      rv.mac_lat = $urandom_range(1, 4);
      rv.rdy_mode = 1;
      rv.never = 0;
      rv.stray = $urandom_range(0, 1);
      rv.hold_at = -1;
      rv.hold_len = 0;
      rv.exp_hs = out_cols[rd] * out_rows[rd];
      rv.exp_slides = rv.exp_hs - 1;
      rv.exp_macs = rv.exp_hs;
      rv.exp_done = 1;
      rv.exp_err = 0;
      rv.exp_row = out_rows[rd] - 1;
      rv.exp_col = out_cols[rd] - 1;
      rv.exp_busy = 0;
      run_vec(rv);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
